// File: rtl/preamble_seq_pkg.sv
// Shared constants, FSM state encoding and I/Q helper for the preamble sequencer.
package preamble_seq_pkg;

  localparam int STF_LEN = 16;
  localparam int LTF_LEN = 64;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_STF    = 2'd1;
  localparam state_t S_LTF_GI = 2'd2;
  localparam state_t S_LTF    = 2'd3;

  // Halve I and Q independently: arithmetic shift keeps the sign and floors.
  function automatic logic [31:0] iq_half(input logic [31:0] iq);
    logic [15:0] w_i;
    logic [15:0] w_q;
    w_i = 16'($signed(iq[31:16]) >>> 1);
    w_q = 16'($signed(iq[15:0]) >>> 1);
    return {w_i, w_q};
  endfunction

endpackage

// File: rtl/preamble_seq_iq_out_stage.sv
// Output register for the preamble stream: loads a ROM word (optionally
// halved), holds it while downstream stalls, and drops valid once consumed.
module iq_out_stage
  import preamble_seq_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_half,
  input  logic [31:0] i_data,
  input  logic        i_last,
  input  logic        i_ready,
  output logic [31:0] o_iq,
  output logic        o_valid,
  output logic        o_last
);

  // Load a new sample when asked; otherwise clear valid after a transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_iq    <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else if (i_load) begin
      o_iq    <= i_half ? iq_half(i_data) : i_data;
      o_valid <= 1'b1;
      o_last  <= i_last;
    end else if (i_ready) begin
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/preamble_seq.sv
// Preamble sequencer: walks the STF ROM, then the LTF guard and LTF symbols,
// streaming one sample per cycle through a single-register output stage.
module preamble_seq
  import preamble_seq_pkg::*;
#(
  parameter int STF_REPS   = 10,
  parameter int LTF_GI_LEN = 32,
  parameter int LTF_SYMS   = 2,
  parameter int WINDOW_EN  = 1
) (
  input  logic        clk,
  input  logic        phy_tx_arest,
  input  logic        start,
  output logic [3:0]  stf_addr,
  input  logic [31:0] stf_dout,
  output logic [5:0]  ltf_addr,
  input  logic [31:0] ltf_dout,
  output logic [31:0] out_iq,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        done
);

  localparam int STF_N = STF_REPS * STF_LEN;
  localparam int LTF_N = LTF_SYMS * LTF_LEN;
  localparam int MAX_A = (STF_N > LTF_N) ? STF_N : LTF_N;
  localparam int MAX_N = (MAX_A > LTF_GI_LEN) ? MAX_A : LTF_GI_LEN;
  localparam int IDX_W = ($clog2(MAX_N) > 6) ? $clog2(MAX_N) : 6;

  localparam logic [IDX_W-1:0] STF_END = IDX_W'(STF_N - 1);
  localparam logic [IDX_W-1:0] GI_END  = IDX_W'(LTF_GI_LEN - 1);
  localparam logic [IDX_W-1:0] LTF_END = IDX_W'(LTF_N - 1);
  localparam logic [5:0]       GI_OFS  = 6'(LTF_LEN - LTF_GI_LEN);

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;

  state_t           w_st;
  logic [IDX_W-1:0] w_cur_idx;
  logic [IDX_W-1:0] w_end_idx;
  logic [31:0]      w_word;
  logic             w_accept;
  logic             w_load;
  logic             w_phase_end;
  logic             w_is_last;
  logic             w_half;
  logic             w_final;

  // A start in IDLE is treated as STF index 0 in the same cycle, so the
  // first sample loads on the accepting edge (stf_addr is already 0 in IDLE).
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_st        = w_accept ? S_STF : r_state;
  assign w_cur_idx   = w_accept ? '0 : r_idx;
  assign w_load      = (w_st != S_IDLE) && (!out_valid || out_ready);
  assign w_phase_end = (w_cur_idx == w_end_idx);
  assign w_is_last   = (w_st == S_LTF) && w_phase_end;
  assign w_half      = (WINDOW_EN != 0) && (w_st == S_STF) && (w_cur_idx == '0);
  assign w_final     = out_valid && out_ready && out_last;

  // ROM addressing and word select per phase; addresses rest at 0 elsewhere.
  always_comb begin
    stf_addr  = '0;
    ltf_addr  = '0;
    w_word    = '0;
    w_end_idx = '0;
    case (w_st)
      S_STF: begin
        stf_addr  = w_cur_idx[3:0];
        w_word    = stf_dout;
        w_end_idx = STF_END;
      end
      S_LTF_GI: begin
        ltf_addr  = GI_OFS + w_cur_idx[5:0];
        w_word    = ltf_dout;
        w_end_idx = GI_END;
      end
      S_LTF: begin
        ltf_addr  = w_cur_idx[5:0];
        w_word    = ltf_dout;
        w_end_idx = LTF_END;
      end
      default: ;
    endcase
  end

  // Phase FSM and sample index; the index only moves when a sample loads.
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else if (w_load) begin
      if (w_phase_end) begin
        r_idx <= '0;
        case (w_st)
          S_STF:    r_state <= S_LTF_GI;
          S_LTF_GI: r_state <= S_LTF;
          default:  r_state <= S_IDLE;
        endcase
      end else begin
        r_state <= w_st;
        r_idx   <= w_cur_idx + IDX_W'(1);
      end
    end else if (w_accept) begin
      r_state <= S_STF;
      r_idx   <= '0;
    end
  end

  // busy spans start acceptance to the final transfer; done pulses after it.
  always_ff @(posedge clk or posedge phy_tx_arest) begin
    if (phy_tx_arest) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= w_final;
      if (w_accept)     busy <= 1'b1;
      else if (w_final) busy <= 1'b0;
    end
  end

  iq_out_stage u_out (
    .i_clk   (clk),
    .i_rst   (phy_tx_arest),
    .i_load  (w_load),
    .i_half  (w_half),
    .i_data  (w_word),
    .i_last  (w_is_last),
    .i_ready (out_ready),
    .o_iq    (out_iq),
    .o_valid (out_valid),
    .o_last  (out_last)
  );

endmodule

// File: tb/tb_preamble_seq.sv
// Scoreboard bench for preamble_seq: stimulus pushes expected samples, a
// negedge monitor pops and compares on every transfer and checks stall holds.
module tb_preamble_seq;

  localparam int TOTAL = 320;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, out_ready;
  logic [3:0]  stf_addr;
  logic [5:0]  ltf_addr;
  logic [31:0] stf_dout, ltf_dout, out_iq;
  logic        out_valid, out_last, busy, done;

  logic        nw_start, nw_ready;
  logic [3:0]  nw_stf_addr;
  logic [5:0]  nw_ltf_addr;
  logic [31:0] nw_stf_dout, nw_ltf_dout, nw_iq;
  logic        nw_valid, nw_last, nw_busy, nw_done;

  int checks = 0;
  int fails  = 0;
  int xfer_cnt = 0;
  int busy_cycles = 0;
  bit rnd = 1'b0;
  logic [32:0] exp_q[$];
  logic [31:0] cap [0:TOTAL-1];

  always #5 clk = ~clk;

  function automatic logic [31:0] stf_rom(input logic [3:0] a);
    logic [15:0] x;
    x = {12'd0, a};
    case (a)
      4'd0:    return 32'h02f2_02f2;
      4'd1:    return 32'hfc27_0198;
      4'd15:   return 32'h0198_fc27;
      default: return {16'(x * 16'h0111 + 16'h0011), 16'(16'hf000 - x * 16'h0101)};
    endcase
  endfunction

  function automatic logic [31:0] ltf_rom(input logic [5:0] a);
    logic [15:0] x;
    x = {10'd0, a};
    return {16'(16'h0400 + x * 16'h0013), 16'(16'hfe00 - x * 16'h0021)};
  endfunction

  // Floor division by two, written as integer arithmetic.
  function automatic logic [15:0] fhalf(input logic [15:0] v);
    int s;
    s = int'($signed(v));
    s = (s < 0) ? (s - 1) / 2 : s / 2;
    return 16'(s);
  endfunction

  function automatic logic [31:0] exp_sample(input int n, input bit win);
    logic [31:0] r;
    if (n < 160)      r = stf_rom(4'(n % 16));
    else if (n < 192) r = ltf_rom(6'(32 + n - 160));
    else              r = ltf_rom(6'((n - 192) % 64));
    if (win && n == 0) r = {fhalf(r[31:16]), fhalf(r[15:0])};
    return r;
  endfunction

  assign stf_dout    = stf_rom(stf_addr);
  assign ltf_dout    = ltf_rom(ltf_addr);
  assign nw_stf_dout = stf_rom(nw_stf_addr);
  assign nw_ltf_dout = ltf_rom(nw_ltf_addr);

  preamble_seq u_dut (
    .clk(clk), .phy_tx_arest(rst), .start(start),
    .stf_addr(stf_addr), .stf_dout(stf_dout),
    .ltf_addr(ltf_addr), .ltf_dout(ltf_dout),
    .out_iq(out_iq), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .done(done)
  );

  preamble_seq #(.WINDOW_EN(0)) u_dut_nw (
    .clk(clk), .phy_tx_arest(rst), .start(nw_start),
    .stf_addr(nw_stf_addr), .stf_dout(nw_stf_dout),
    .ltf_addr(nw_ltf_addr), .ltf_dout(nw_ltf_dout),
    .out_iq(nw_iq), .out_valid(nw_valid), .out_ready(nw_ready),
    .out_last(nw_last), .busy(nw_busy), .done(nw_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every transfer against the queue; verify stall holds.
  logic        p_stall = 1'b0;
  logic [31:0] p_iq;
  logic        p_last;
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        checks++;
        if (!out_valid || out_iq !== p_iq || out_last !== p_last) begin
          fails++;
          $display("FAIL stall_hold actual=%b/%h/%b expected=1/%h/%b",
                   out_valid, out_iq, out_last, p_iq, p_last);
        end
      end
      if (busy) busy_cycles++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_xfer actual=%h expected=none", out_iq);
        end else begin
          e = exp_q.pop_front();
          if ({out_last, out_iq} !== e) begin
            fails++;
            $display("FAIL sample[%0d] actual=%b/%h expected=%b/%h",
                     xfer_cnt, out_last, out_iq, e[32], e[31:0]);
          end
        end
        if (xfer_cnt < TOTAL) cap[xfer_cnt] = out_iq;
        xfer_cnt++;
      end
      p_stall = out_valid && !out_ready;
      p_iq    = out_iq;
      p_last  = out_last;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic push_seq();
    for (int n = 0; n < TOTAL; n++)
      exp_q.push_back({(n == TOTAL - 1), exp_sample(n, 1'b1)});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int bound);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step();
      if (done) begin ok = 1'b1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_xfer(input int n);
    for (int i = 0; i < 4000 && xfer_cnt < n; i++) step();
    chk("reach_xfer", 32'(xfer_cnt >= n), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; nw_start = 1'b0; nw_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_iq", out_iq, 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stf_addr", 32'(stf_addr), 32'd0);
    chk("rst_ltf_addr", 32'(ltf_addr), 32'd0);
    rst = 1'b0;
    step();

    // Straight run, ready always high.
    xfer_cnt = 0; busy_cycles = 0;
    push_seq();
    pulse_start();
    chk("lat1_valid", 32'(out_valid), 32'd1);
    wait_done("t1_done", 400);
    chk("t1_valid_drop", 32'(out_valid), 32'd0);
    chk("t1_busy_clear", 32'(busy), 32'd0);
    chk("t1_count", 32'(xfer_cnt), 32'(TOTAL));
    chk("t1_busy_cycles", 32'(busy_cycles), 32'(TOTAL));
    chk("s0", cap[0], 32'h0179_0179);
    chk("s1", cap[1], 32'hfc27_0198);
    chk("s16", cap[16], 32'h02f2_02f2);
    chk("s159", cap[159], 32'h0198_fc27);
    chk("s160", cap[160], ltf_rom(6'd32));
    chk("s192", cap[192], ltf_rom(6'd0));
    chk("s256", cap[256], ltf_rom(6'd0));
    chk("idle_addr", {stf_addr, ltf_addr}, 32'd0);

    // Random backpressure.
    rnd = 1'b1; xfer_cnt = 0;
    push_seq();
    pulse_start();
    wait_done("t2_done", 2000);
    rnd = 1'b0;
    chk("t2_count", 32'(xfer_cnt), 32'(TOTAL));
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Start mid-sequence is ignored.
    step();
    xfer_cnt = 0;
    push_seq();
    pulse_start();
    wait_xfer(50);
    pulse_start();
    wait_done("t3_done", 400);
    repeat (3) step();
    chk("t3_count", 32'(xfer_cnt), 32'(TOTAL));
    chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-sequence, then restart from sample 0.
    xfer_cnt = 0;
    push_seq();
    pulse_start();
    wait_xfer(100);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_iq", out_iq, 32'd0);
    chk("mrst_last", 32'(out_last), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    step();
    rst = 1'b0;
    step();
    xfer_cnt = 0;
    push_seq();
    pulse_start();
    wait_done("t4_done", 400);
    chk("t4_s0", cap[0], 32'h0179_0179);
    chk("t4_count", 32'(xfer_cnt), 32'(TOTAL));

    // Back-to-back: start issued in the done cycle.
    xfer_cnt = 0;
    push_seq();
    pulse_start();
    wait_done("t5a_done", 400);
    push_seq();
    pulse_start();
    chk("t5_busy_again", 32'(busy), 32'd1);
    chk("t5_valid_again", 32'(out_valid), 32'd1);
    wait_done("t5b_done", 400);
    chk("t5_count", 32'(xfer_cnt), 32'(2 * TOTAL));
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Window disabled: first sample passes unmodified.
    nw_start = 1'b1;
    step();
    nw_start = 1'b0;
    chk("nw_valid", 32'(nw_valid), 32'd1);
    chk("nw_s0", nw_iq, 32'h02f2_02f2);
    begin
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
        step();
        if (nw_done) begin ok = 1'b1; break; end
      end
      chk("nw_done", 32'(ok), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
